// File: rtl/cmpacc_pkg.sv
// Shared constants and types for cmpacc, its frame loader and their benches.
// Result field positions describe the packed cmpacc result word.
package cmpacc_pkg;

  localparam int CMP_ROWS  = 64;
  localparam int CMP_COLS  = 24;
  localparam int CMP_BMP_W = CMP_ROWS * CMP_COLS;
  localparam int CMP_RES_W = 13;

  localparam int X_OFF_LSB  = 0;
  localparam int X_OFF_MSB  = 4;
  localparam int Y_OFF_LSB  = 5;
  localparam int Y_OFF_MSB  = 10;
  localparam int FLAG_A_BIT = 11;
  localparam int FLAG_B_BIT = 12;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/cmpacc_frame_loader_if.sv
// Row stream carrying one bitmap row per valid/ready handshake.
// row_sof marks the row that begins a new frame.
interface cmpacc_frame_loader_if #(
  parameter int COLS = cmpacc_pkg::CMP_COLS
);

  logic [COLS-1:0] row_in;
  logic            row_valid;
  logic            row_sof;
  logic            row_ready;

  modport master (
    output row_in,
    output row_valid,
    output row_sof,
    input  row_ready
  );

  modport slave (
    input  row_in,
    input  row_valid,
    input  row_sof,
    output row_ready
  );

endinterface

// File: rtl/cmpacc_frame_loader.sv
// Assembles streamed rows into a full cmpacc frame, strobes wren, then holds the
// frame until cmpacc reports done (or the wait times out) and captures the result.
module cmpacc_frame_loader
  import cmpacc_pkg::*;
#(
  parameter int ROWS    = CMP_ROWS,
  parameter int COLS    = CMP_COLS,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  cmpacc_frame_loader_if.slave      rowIf,
  output logic [ROWS*COLS-1:0]      bitmap,
  output logic                      wren,
  input  logic [CMP_RES_W-1:0]      cmp_result,
  input  logic                      cmp_done,
  output logic [CMP_RES_W-1:0]      result_out,
  output logic                      result_valid,
  output logic                      timeout,
  output logic                      resync_err
);

  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int BW = $clog2(ROWS * COLS);

  cmp_state_e           r_state;
  logic [RW-1:0]        r_rowCnt;
  logic [ROWS*COLS-1:0] r_bitmap;
  logic                 r_wren;
  logic [CMP_RES_W-1:0] r_result;
  logic                 r_resultValid;
  logic                 r_timeout;
  logic                 r_resyncErr;
  logic                 r_armed;
  logic [TW-1:0]        r_tmr;

  logic                 w_accept;
  logic                 w_resync;
  logic [RW-1:0]        w_slot;
  logic [BW-1:0]        w_slotMsb;

  assign rowIf.row_ready = (r_state == FILL) && !rst;
  assign w_accept        = rowIf.row_valid && rowIf.row_ready;
  assign w_resync        = w_accept && rowIf.row_sof && (r_rowCnt != '0);
  assign w_slot          = w_resync ? '0 : r_rowCnt;
  // Row 0 is the top of the picture and therefore occupies the bitmap MSBs.
  assign w_slotMsb       = BW'((ROWS * COLS - 1) - COLS * int'(w_slot));

  // A stale done left over from the previous frame is ignored until cmpacc has
  // been seen low at least once inside WAIT (r_armed).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FILL;
      r_rowCnt      <= '0;
      r_bitmap      <= '0;
      r_wren        <= 1'b0;
      r_result      <= '0;
      r_resultValid <= 1'b0;
      r_timeout     <= 1'b0;
      r_resyncErr   <= 1'b0;
      r_armed       <= 1'b0;
      r_tmr         <= '0;
    end else begin
      r_wren        <= 1'b0;
      r_resultValid <= 1'b0;
      r_timeout     <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_bitmap[w_slotMsb -: COLS] <= rowIf.row_in;
            if (w_resync) begin
              r_rowCnt    <= RW'(1);
              r_resyncErr <= 1'b1;
            end else if (r_rowCnt == RW'(ROWS - 1)) begin
              r_rowCnt <= '0;
              r_wren   <= 1'b1;
              r_state  <= LOAD;
            end else begin
              r_rowCnt <= r_rowCnt + RW'(1);
            end
          end
        end
        LOAD: begin
          r_state <= WAIT;
          r_tmr   <= '0;
          r_armed <= 1'b0;
        end
        WAIT: begin
          r_tmr <= r_tmr + TW'(1);
          if (!cmp_done) begin
            r_armed <= 1'b1;
          end
          if (r_armed && cmp_done) begin
            r_result      <= cmp_result;
            r_resultValid <= 1'b1;
            r_state       <= FILL;
          end else if (r_tmr == TW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bitmap       = r_bitmap;
  assign wren         = r_wren;
  assign result_out   = r_result;
  assign result_valid = r_resultValid;
  assign timeout      = r_timeout;
  assign resync_err   = r_resyncErr;

endmodule

// File: tb/tb_cmpacc_frame_loader.sv
// Bench for cmpacc_frame_loader: a behavioural cmpacc stand-in (result = bitmap
// popcount) downstream, a row-array model checked every cycle, plus pinned literals.
module tb_cmpacc_frame_loader;
  import cmpacc_pkg::*;

  localparam int TIMEOUT = 1024;
  localparam int LAT     = 20;
  localparam int BW      = CMP_BMP_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [CMP_BMP_W-1:0] bitmap;
  logic                 wren;
  logic [CMP_RES_W-1:0] cmp_result;
  logic                 cmp_done;
  logic [CMP_RES_W-1:0] result_out;
  logic                 result_valid;
  logic                 timeout;
  logic                 resync_err;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  cmpacc_frame_loader_if rowIf ();

  cmpacc_frame_loader #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .rowIf        (rowIf),
    .bitmap       (bitmap),
    .wren         (wren),
    .cmp_result   (cmp_result),
    .cmp_done     (cmp_done),
    .result_out   (result_out),
    .result_valid (result_valid),
    .timeout      (timeout),
    .resync_err   (resync_err)
  );

  // cmpacc stand-in: done stays stale for a few cycles after wren, then drops,
  // then rises LAT cycles after wren with the popcount of the loaded frame.
  logic                 stubDone  = 1'b1;
  logic                 stubStuck = 1'b0;
  int                   stubCnt   = 0;
  logic [CMP_RES_W-1:0] stubRes   = '0;

  always @(posedge clk) begin
    if (wren) begin
      stubCnt <= LAT;
      stubRes <= CMP_RES_W'($countones(bitmap));
    end else if (stubCnt > 0) begin
      stubCnt <= stubCnt - 1;
      if (stubCnt == LAT - 3) stubDone <= 1'b0;
      if (stubCnt == 1) stubDone <= 1'b1;
    end
  end

  assign cmp_done   = stubStuck | stubDone;
  assign cmp_result = stubRes;

  // Model: frame kept as an array of rows; phase 0 = collecting rows,
  // 1 = load cycle, 2 = waiting for cmpacc.
  logic [23:0]          mRows [CMP_ROWS];
  int                   mPhase   = 0;
  int                   mCnt     = 0;
  int                   mWait    = 0;
  bit                   mSawLow  = 1'b0;
  bit                   mLive    = 1'b0;
  logic                 expWren  = 1'b0;
  logic                 expRv    = 1'b0;
  logic                 expTo    = 1'b0;
  logic                 expResync = 1'b0;
  logic [CMP_RES_W-1:0] expResult = '0;

  always @(posedge clk) begin
    expWren = 1'b0;
    expRv   = 1'b0;
    expTo   = 1'b0;
    if (rst) begin
      mLive = 1'b1;
      foreach (mRows[i]) mRows[i] = '0;
      mPhase    = 0;
      mCnt      = 0;
      mWait     = 0;
      mSawLow   = 1'b0;
      expResult = '0;
      expResync = 1'b0;
    end else if (mLive) begin
      if (mPhase == 0) begin
        if (rowIf.row_valid) begin
          if (rowIf.row_sof && mCnt != 0) begin
            mRows[0]  = rowIf.row_in;
            mCnt      = 1;
            expResync = 1'b1;
          end else begin
            mRows[mCnt] = rowIf.row_in;
            mCnt++;
            if (mCnt == CMP_ROWS) begin
              mCnt    = 0;
              mPhase  = 1;
              expWren = 1'b1;
            end
          end
        end
      end else if (mPhase == 1) begin
        mPhase  = 2;
        mWait   = 0;
        mSawLow = 1'b0;
      end else begin
        if (mSawLow && cmp_done) begin
          expResult = cmp_result;
          expRv     = 1'b1;
          mPhase    = 0;
        end else if (mWait == TIMEOUT - 1) begin
          expTo  = 1'b1;
          mPhase = 0;
        end
        if (!cmp_done) mSawLow = 1'b1;
        mWait++;
      end
    end
  end

  function automatic logic [CMP_BMP_W-1:0] modelBitmap();
    logic [CMP_BMP_W-1:0] b;
    b = '0;
    for (int i = 0; i < CMP_ROWS; i++) b[CMP_BMP_W-1-CMP_COLS*i -: CMP_COLS] = mRows[i];
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [CMP_BMP_W-1:0] actual,
                             input logic [CMP_BMP_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mLive) begin
      checkOutput("row_ready",    BW'(rowIf.row_ready), BW'(mPhase == 0 && !rst));
      checkOutput("wren",         BW'(wren),            BW'(expWren));
      checkOutput("result_valid", BW'(result_valid),    BW'(expRv));
      checkOutput("timeout",      BW'(timeout),         BW'(expTo));
      checkOutput("resync_err",   BW'(resync_err),      BW'(expResync));
      checkOutput("result_out",   BW'(result_out),      BW'(expResult));
      checkOutput("bitmap",       bitmap,               modelBitmap());
    end
  end

  int wrenCount = 0;
  int rvCount   = 0;
  int accCount  = 0;
  int cycles    = 0;

  always @(negedge clk) begin
    if (wren) wrenCount++;
    if (result_valid) rvCount++;
    if (rowIf.row_valid && rowIf.row_ready) accCount++;
  end

  always @(posedge clk) begin
    cycles++;
    if (cycles > 60000) begin
      $display("[TB] FAIL watchdog: got %0d cycles expected fewer than 60000", cycles);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  function automatic logic [23:0] rowValue(input int p, input int i);
    if (p == 0) return (i >= 35 && i < 62) ? 24'h3F0000 : 24'h000000;
    return {8'(p), 8'(i), 8'hC3};
  endfunction

  // Presents one row and returns (at posedge+2) right after it is accepted.
  task automatic applyStimulus(input logic [23:0] row, input logic sof, input int gap);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    rowIf.row_in    = row;
    rowIf.row_sof   = sof;
    rowIf.row_valid = 1'b1;
    while (!acc && n < 3000) begin
      @(negedge clk);
      acc = rowIf.row_ready;
      @(posedge clk);
      #2;
      n++;
    end
    if (!acc) checkOutput("row handshake", BW'(0), BW'(1));
    if (gap > 0) begin
      rowIf.row_valid = 1'b0;
      rowIf.row_sof   = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #2;
      end
    end
  endtask

  task automatic sendFrame(input int p, input int first, input int nRows, input int gap,
                           input bit hold);
    for (int i = first; i < first + nRows; i++) applyStimulus(rowValue(p, i), i == 0, gap);
    if (!hold) begin
      rowIf.row_valid = 1'b0;
      rowIf.row_sof   = 1'b0;
    end
  endtask

  task automatic waitEvent(input int limit, output int kind);
    kind = 0;
    for (int n = 0; n < limit && kind == 0; n++) begin
      @(negedge clk);
      if (result_valid) kind = 1;
      else if (timeout) kind = 2;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic applyReset(input int n);
    rowIf.row_valid = 1'b0;
    rowIf.row_sof   = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("row_ready during rst", BW'(rowIf.row_ready), BW'(0));
    repeat (n) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
  endtask

  initial begin
    int k, w0, r0, a0, c;
    rowIf.row_in    = '0;
    rowIf.row_valid = 1'b0;
    rowIf.row_sof   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset bitmap",     bitmap,                 BW'(0));
    checkOutput("reset result_out", BW'(result_out),        BW'(0));
    checkOutput("reset resync_err", BW'(resync_err),        BW'(0));
    checkOutput("reset row_ready",  BW'(rowIf.row_ready),   BW'(1));
    @(posedge clk);
    #2;

    $display("[TB] test 1: symbol frame");
    w0 = wrenCount; r0 = rvCount;
    sendFrame(0, 0, 64, 0, 1'b0);
    @(negedge clk);
    checkOutput("t1 wren after row 64", BW'(wren), BW'(1));
    @(posedge clk);
    #2;
    waitEvent(1000, k);
    checkOutput("t1 completion kind", BW'(k), BW'(1));
    checkOutput("t1 result_out", BW'(result_out), BW'(13'd162));
    checkOutput("t1 wren pulses", BW'(wrenCount - w0), BW'(1));
    checkOutput("t1 result pulses", BW'(rvCount - r0), BW'(1));
    checkOutput("t1 model row 40", BW'(mRows[40]), BW'(24'h3F0000));
    checkOutput("t1 bitmap row 40", BW'(bitmap[CMP_BMP_W-1-24*40 -: 24]), BW'(24'h3F0000));

    $display("[TB] test 2: continuous valid across two frames");
    r0 = rvCount; a0 = accCount;
    sendFrame(2, 0, 64, 0, 1'b1);
    sendFrame(3, 0, 64, 0, 1'b0);
    waitEvent(1000, k);
    checkOutput("t2 completion kind", BW'(k), BW'(1));
    checkOutput("t2 result_out", BW'(result_out), BW'(13'd576));
    checkOutput("t2 result pulses", BW'(rvCount - r0), BW'(2));
    checkOutput("t2 rows accepted", BW'(accCount - a0), BW'(128));
    checkOutput("t2 bitmap row 63", BW'(bitmap[23:0]), BW'(24'h033FC3));

    $display("[TB] test 3: resync at row 10");
    sendFrame(4, 0, 10, 0, 1'b0);
    sendFrame(7, 0, 64, 0, 1'b0);
    waitEvent(1000, k);
    checkOutput("t3 completion kind", BW'(k), BW'(1));
    checkOutput("t3 resync_err", BW'(resync_err), BW'(1));
    checkOutput("t3 result_out", BW'(result_out), BW'(13'd640));

    $display("[TB] test 4: done stuck high");
    stubStuck = 1'b1;
    r0 = rvCount;
    sendFrame(8, 0, 64, 0, 1'b0);
    c = 0;
    @(negedge clk);
    while (!timeout && c < 2000) begin
      @(negedge clk);
      c++;
    end
    // wren rises in the load cycle; timeout follows one load cycle plus TIMEOUT wait cycles.
    checkOutput("t4 timeout latency", BW'(c), BW'(TIMEOUT + 1));
    checkOutput("t4 back to fill", BW'(rowIf.row_ready), BW'(1));
    checkOutput("t4 no result pulse", BW'(rvCount - r0), BW'(0));
    checkOutput("t4 result kept", BW'(result_out), BW'(13'd640));
    @(posedge clk);
    #2;
    stubStuck = 1'b0;

    $display("[TB] test 5: reset in wait and mid-fill");
    w0 = wrenCount; r0 = rvCount;
    sendFrame(9, 0, 64, 0, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #2;
    end
    applyReset(2);
    repeat (30) begin
      @(posedge clk);
      #2;
    end
    checkOutput("t5 no result after rst", BW'(rvCount - r0), BW'(0));
    checkOutput("t5 result_out cleared", BW'(result_out), BW'(0));
    checkOutput("t5 resync cleared", BW'(resync_err), BW'(0));
    sendFrame(5, 0, 30, 0, 1'b0);
    w0 = wrenCount;
    applyReset(1);
    @(negedge clk);
    checkOutput("t5 bitmap cleared", bitmap, BW'(0));
    @(posedge clk);
    #2;
    sendFrame(6, 0, 64, 0, 1'b0);
    waitEvent(1000, k);
    checkOutput("t5 completion kind", BW'(k), BW'(1));
    checkOutput("t5 result_out", BW'(result_out), BW'(13'd576));
    checkOutput("t5 wren pulses", BW'(wrenCount - w0), BW'(1));

    $display("[TB] test 6: gapped stream");
    sendFrame(0, 0, 64, 2, 1'b0);
    waitEvent(1000, k);
    checkOutput("t6 completion kind", BW'(k), BW'(1));
    checkOutput("t6 result_out", BW'(result_out), BW'(13'd162));
    checkOutput("t6 bitmap row 61", BW'(bitmap[CMP_BMP_W-1-24*61 -: 24]), BW'(24'h3F0000));

    repeat (3) begin
      @(posedge clk);
      #2;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
